// File: rtl/multicycle_control_fsm_pkg.sv
// Shared encodings for the multicycle RV32I control path: ALU operations,
// opcodes, FSM states, write-back selects and the opcode classifier.
package rv_ctrl_pkg;

  typedef enum logic [3:0] {
    ALU_ADD    = 4'd0,
    ALU_SUB    = 4'd1,
    ALU_SLL    = 4'd2,
    ALU_SLT    = 4'd3,
    ALU_SLTU   = 4'd4,
    ALU_XOR    = 4'd5,
    ALU_SRL    = 4'd6,
    ALU_SRA    = 4'd7,
    ALU_OR     = 4'd8,
    ALU_AND    = 4'd9,
    ALU_PASS_B = 4'd10
  } alu_op_e;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_HALT   = 3'd5
  } state_e;

  localparam logic [1:0] WB_ALU = 2'd0;
  localparam logic [1:0] WB_MEM = 2'd1;
  localparam logic [1:0] WB_PC4 = 2'd2;

  typedef enum logic [3:0] {
    CL_OP      = 4'd0,
    CL_OP_IMM  = 4'd1,
    CL_LOAD    = 4'd2,
    CL_STORE   = 4'd3,
    CL_LUI     = 4'd4,
    CL_AUIPC   = 4'd5,
    CL_BRANCH  = 4'd6,
    CL_JAL     = 4'd7,
    CL_JALR    = 4'd8,
    CL_SYSTEM  = 4'd9,
    CL_ILLEGAL = 4'd10
  } opclass_e;

  // Map a 7-bit major opcode onto the instruction class the FSM sequences by.
  function automatic opclass_e classify(input logic [6:0] opcode);
    case (opcode)
      OPC_OP:     return CL_OP;
      OPC_OP_IMM: return CL_OP_IMM;
      OPC_LOAD:   return CL_LOAD;
      OPC_STORE:  return CL_STORE;
      OPC_LUI:    return CL_LUI;
      OPC_AUIPC:  return CL_AUIPC;
      OPC_BRANCH: return CL_BRANCH;
      OPC_JAL:    return CL_JAL;
      OPC_JALR:   return CL_JALR;
      OPC_SYSTEM: return CL_SYSTEM;
      default:    return CL_ILLEGAL;
    endcase
  endfunction

  // Arithmetic op for OP / OP-IMM. funct7[5] selects SUB only for register
  // forms (ADDI has no SUB variant) and SRA for both forms.
  function automatic alu_op_e arith_op(input logic [2:0] funct3,
                                       input logic       funct7_b5,
                                       input logic       is_reg);
    case (funct3)
      3'b000: return (is_reg && funct7_b5) ? ALU_SUB : ALU_ADD;
      3'b001: return ALU_SLL;
      3'b010: return ALU_SLT;
      3'b011: return ALU_SLTU;
      3'b100: return ALU_XOR;
      3'b101: return funct7_b5 ? ALU_SRA : ALU_SRL;
      3'b110: return ALU_OR;
      3'b111: return ALU_AND;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_control_fsm_alu_op_decoder.sv
// Combinational ALU-control decode: opcode/funct3/funct7[5] to alu_op and
// the two operand selects. Stateless so a pipelined decode stage can reuse it.
module alu_op_decoder
  import rv_ctrl_pkg::*;
(
  input  logic [6:0] opcode_i,
  input  logic [2:0] funct3_i,
  input  logic       funct7_b5_i,
  output logic [3:0] alu_op_o,
  output logic       d1_sel_o,
  output logic       d2_sel_o
);

  // Operand and operation selection per instruction class.
  always_comb begin
    alu_op_o = ALU_ADD;
    d1_sel_o = 1'b0;
    d2_sel_o = 1'b0;
    case (classify(opcode_i))
      CL_OP: begin
        alu_op_o = arith_op(funct3_i, funct7_b5_i, 1'b1);
      end
      CL_OP_IMM: begin
        alu_op_o = arith_op(funct3_i, funct7_b5_i, 1'b0);
        d2_sel_o = 1'b1;
      end
      CL_LOAD, CL_STORE, CL_JALR: begin
        d2_sel_o = 1'b1;
      end
      CL_LUI: begin
        alu_op_o = ALU_PASS_B;
        d2_sel_o = 1'b1;
      end
      // Targets and AUIPC are relative to the instruction's own address.
      CL_AUIPC, CL_BRANCH, CL_JAL: begin
        d1_sel_o = 1'b1;
        d2_sel_o = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/multicycle_control_fsm.sv
// Sequencing controller for the multicycle RV32I core. Steps each
// instruction through FETCH/DECODE/EXEC/MEM/WB and drives the ALU controls,
// PC/IR/register-file strobes and the memory handshake.
module multicycle_control_fsm
  import rv_ctrl_pkg::*;
#(
  parameter bit RESET_HALT = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instr,
  input  logic        branch_cond,
  input  logic        mem_ready,
  output logic [3:0]  alu_op,
  output logic        d1_sel,
  output logic        d2_sel,
  output logic        ir_we,
  output logic        pc_we,
  output logic        pc_sel,
  output logic        rf_we,
  output logic [1:0]  wb_sel,
  output logic        mem_req,
  output logic        mem_we,
  output logic        addr_sel,
  output logic        halted
);

  state_e     state_q, state_d;
  opclass_e   opclass;
  logic [3:0] dec_alu_op;
  logic       dec_d1_sel;
  logic       dec_d2_sel;
  logic       unused_instr_bits;

  assign opclass           = classify(instr[6:0]);
  assign unused_instr_bits = ^{instr[31], instr[29:15], instr[11:7]};

  alu_op_decoder u_alu_op_decoder (
    .opcode_i    (instr[6:0]),
    .funct3_i    (instr[14:12]),
    .funct7_b5_i (instr[30]),
    .alu_op_o    (dec_alu_op),
    .d1_sel_o    (dec_d1_sel),
    .d2_sel_o    (dec_d2_sel)
  );

  // State register with synchronous reset into FETCH (or HALT for bring-up).
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RESET_HALT ? ST_HALT : ST_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state selection.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_FETCH: begin
        if (mem_ready) state_d = ST_DECODE;
      end
      ST_DECODE: begin
        state_d = (opclass == CL_ILLEGAL) ? ST_HALT : ST_EXEC;
      end
      ST_EXEC: begin
        case (opclass)
          CL_LOAD, CL_STORE: state_d = ST_MEM;
          CL_BRANCH:         state_d = ST_FETCH;
          CL_SYSTEM:         state_d = ST_HALT;
          default:           state_d = ST_WB;
        endcase
      end
      ST_MEM: begin
        if (mem_ready) state_d = (opclass == CL_STORE) ? ST_FETCH : ST_WB;
      end
      ST_WB:   state_d = ST_FETCH;
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_FETCH;
    endcase
  end

  // Output decode from state and instruction. While rst is high every output
  // is forced to its reset value so no write strobe or memory request can
  // escape from whatever state was interrupted.
  always_comb begin
    alu_op   = ALU_ADD;
    d1_sel   = 1'b0;
    d2_sel   = 1'b0;
    ir_we    = 1'b0;
    pc_we    = 1'b0;
    pc_sel   = 1'b0;
    rf_we    = 1'b0;
    wb_sel   = WB_ALU;
    mem_req  = 1'b0;
    mem_we   = 1'b0;
    addr_sel = 1'b0;
    halted   = 1'b0;
    if (!rst) begin
      case (state_q)
        ST_FETCH: begin
          mem_req = 1'b1;
          if (mem_ready) begin
            ir_we = 1'b1;
            pc_we = 1'b1;
          end
        end
        ST_EXEC: begin
          alu_op = dec_alu_op;
          d1_sel = dec_d1_sel;
          d2_sel = dec_d2_sel;
          case (opclass)
            CL_BRANCH: begin
              pc_we  = branch_cond;
              pc_sel = 1'b1;
            end
            CL_JAL, CL_JALR: begin
              pc_we  = 1'b1;
              pc_sel = 1'b1;
            end
            default: ;
          endcase
        end
        ST_MEM: begin
          // ALU controls held so the effective address stays stable.
          alu_op   = dec_alu_op;
          d1_sel   = dec_d1_sel;
          d2_sel   = dec_d2_sel;
          mem_req  = 1'b1;
          addr_sel = 1'b1;
          mem_we   = (opclass == CL_STORE);
        end
        ST_WB: begin
          alu_op = dec_alu_op;
          d1_sel = dec_d1_sel;
          d2_sel = dec_d2_sel;
          rf_we  = 1'b1;
          case (opclass)
            CL_LOAD:         wb_sel = WB_MEM;
            CL_JAL, CL_JALR: wb_sel = WB_PC4;
            default:         wb_sel = WB_ALU;
          endcase
        end
        ST_HALT: begin
          halted = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
